apb_master_arb: RTL and testbench
=================================

// Module: apb_master_arb
// PURPOSE
//  Two-requester APB master: arbitrates register accesses from two local clients
//  and sequences the APB SETUP/ACCESS protocol toward the register-file slave
//  (address decoder plus RW/RO registers). Round-robin fairness, PREADY wait-state
//  support, access timeout reported as error. Sits between the control clients
//  and the APB slave bus.
// PARAMETERS
//  AWIDTH   4   APB address width
//  DWIDTH   8   APB data width
//  TIMEOUT  15  max ACCESS cycles without PREADY before abort (1..2**TWIDTH-1)
//  TWIDTH   4   width of timeout counter
// PORTS
//  PCLK         in   1       clock, all logic on rising edge
//  PRESET       in   1       reset, asynchronous, active-high
//  req0_valid   in   1       client 0 request; held until req0_ack
//  req0_write   in   1       client 0: 1 = write, 0 = read
//  req0_addr    in   AWIDTH  client 0 address
//  req0_wdata   in   DWIDTH  client 0 write data
//  req0_ack     out  1       one-cycle pulse: client 0 request captured
//  resp0_valid  out  1       one-cycle pulse: client 0 transfer done
//  resp0_rdata  out  DWIDTH  read data (0 for writes/timeouts), valid with resp0_valid
//  resp0_err    out  1       PSLVERR or timeout, valid with resp0_valid
//  req1_*/resp1_*            identical set for client 1
//  PSEL         out  1       APB select
//  PENABLE      out  1       APB enable
//  PWRITE       out  1       APB direction
//  PADDR        out  AWIDTH  APB address
//  PWDATA       out  DWIDTH  APB write data
//  PRDATA       in   DWIDTH  APB read data
//  PREADY       in   1       APB ready; tie 1 for zero-wait slaves
//  PSLVERR      in   1       APB slave error, sampled with PREADY
// BEHAVIOUR
//  - All outputs registered. Reset: PSEL/PENABLE/PWRITE=0, PADDR/PWDATA=0, all
//    ack/resp_valid/resp_err/rdata=0, state=IDLE, last_grant=1 (client 0 wins first).
//  - FSM IDLE -> SETUP -> ACCESS -> IDLE. Minimum one IDLE cycle between transfers.
//  - IDLE: if any reqN_valid, grant: only one valid -> that one; both -> client
//    != last_grant. Capture write/addr/wdata into PWRITE/PADDR/PWDATA, set
//    last_grant, go SETUP. Next cycle: PSEL=1, PENABLE=0, reqN_ack=1 (1 cycle).
//  - SETUP: one cycle, go ACCESS (PSEL=1, PENABLE=1), timeout counter cleared.
//  - ACCESS: PADDR/PWRITE/PWDATA stable. PREADY=1 -> next cycle PSEL=PENABLE=0,
//    respN_valid=1, respN_err=PSLVERR, respN_rdata=PRDATA if read else 0; IDLE.
//    PREADY=0 -> counter+1; counter reaching TIMEOUT with PREADY=0 -> abort:
//    PSEL=PENABLE=0, respN_valid=1, respN_err=1, respN_rdata=0; IDLE.
//  - Latency (PREADY=1 immediately): valid seen in IDLE at cycle 0, PSEL cycle 1,
//    PENABLE cycle 2, respN_valid cycle 3. Each wait state adds one cycle.
//  - Client must drop reqN_valid the cycle after req_ack or it is re-served.
//  - PSLVERR/PRDATA ignored outside ACCESS&PREADY. Only granted client sees resp.
//  - PRESET mid-transfer: immediate return to reset values, no response issued.
// TESTING
//  - Read: req0 read addr 5, slave PRDATA=8'hA5, PREADY=1 -> PSEL c1, PENABLE c2,
//    resp0_valid c3 rdata=A5 err=0; req0_ack c1 only.
//  - Write with waits: req1 write addr 2 data 3C, PREADY low 3 cycles -> PWDATA=3C
//    stable through ACCESS, resp1_valid 1 cycle after PREADY, rdata=0.
//  - Arbitration: both valid continuously, 4 transfers -> grant order 0,1,0,1.
//  - Error/timeout: addr 9 -> PSLVERR=1 -> resp_err=1; PREADY stuck 0 -> abort after
//    exactly 15 ACCESS cycles, resp_err=1, rdata=0, PSEL drops.
//  - Reset mid-ACCESS: assert PRESET -> all outputs 0 asynchronously, no resp pulse;
//    after release, pending req0 served first.

Source files
------------

// File: rtl/apb_master_arb.sv
// apb_master_arb: two-client APB master with round-robin arbitration.
// Accepts register accesses from two local clients and sequences the APB
// SETUP/ACCESS phases to a single slave. Supports PREADY wait states and
// aborts an access with an error when the slave stalls for TIMEOUT cycles.
// Ports:
//   PCLK, PRESET                 clock, async active-high reset
//   reqN_valid/write/addr/wdata  client N request (held until reqN_ack)
//   reqN_ack                     one-cycle pulse, request captured
//   respN_valid/rdata/err        one-cycle completion pulse with read data/error
//   PSEL/PENABLE/PWRITE/PADDR/PWDATA   APB master outputs (registered)
//   PRDATA/PREADY/PSLVERR              APB slave returns
module apb_master_arb #(
  parameter int unsigned AWIDTH  = 4,
  parameter int unsigned DWIDTH  = 8,
  parameter int unsigned TIMEOUT = 15,
  parameter int unsigned TWIDTH  = 4
) (
  input  logic              PCLK,
  input  logic              PRESET,
  input  logic              req0_valid,
  input  logic              req0_write,
  input  logic [AWIDTH-1:0] req0_addr,
  input  logic [DWIDTH-1:0] req0_wdata,
  output logic              req0_ack,
  output logic              resp0_valid,
  output logic [DWIDTH-1:0] resp0_rdata,
  output logic              resp0_err,
  input  logic              req1_valid,
  input  logic              req1_write,
  input  logic [AWIDTH-1:0] req1_addr,
  input  logic [DWIDTH-1:0] req1_wdata,
  output logic              req1_ack,
  output logic              resp1_valid,
  output logic [DWIDTH-1:0] resp1_rdata,
  output logic              resp1_err,
  output logic              PSEL,
  output logic              PENABLE,
  output logic              PWRITE,
  output logic [AWIDTH-1:0] PADDR,
  output logic [DWIDTH-1:0] PWDATA,
  input  logic [DWIDTH-1:0] PRDATA,
  input  logic              PREADY,
  input  logic              PSLVERR
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  state_t             state, state_nxt;
  logic [TWIDTH-1:0]  cnt, cnt_nxt;
  logic               last_grant, last_grant_nxt;

  // Next values of the registered outputs
  logic              psel_nxt, penable_nxt, pwrite_nxt;
  logic [AWIDTH-1:0] paddr_nxt;
  logic [DWIDTH-1:0] pwdata_nxt;
  logic              ack0_nxt, ack1_nxt;
  logic              rv0_nxt, rv1_nxt;
  logic [DWIDTH-1:0] rdata0_nxt, rdata1_nxt;
  logic              err0_nxt, err1_nxt;

  logic              any_req_c;
  logic              gnt_c;
  logic              abort_c;
  logic              done_c;
  logic [DWIDTH-1:0] rdata_c;
  logic              err_c;

  assign any_req_c = req0_valid | req1_valid;

  // Round-robin: with both requesting, the client not served last wins
  always_comb begin
    gnt_c = req1_valid;
    if (req0_valid && req1_valid) gnt_c = ~last_grant;
  end

  // cnt holds the number of wait cycles already spent in ACCESS, so the
  // TIMEOUT-th stalled ACCESS cycle is the one where cnt == TIMEOUT-1
  assign abort_c = (state == ACCESS) && !PREADY && (cnt == TWIDTH'(TIMEOUT - 1));
  assign done_c  = (state == ACCESS) && (PREADY || abort_c);
  assign rdata_c = (PREADY && !PWRITE) ? PRDATA : '0;
  assign err_c   = PREADY ? PSLVERR : 1'b1;

  // State register
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_req_c) state_nxt = SETUP;
      SETUP:   state_nxt = ACCESS;
      ACCESS:  if (done_c) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output / datapath next values
  always_comb begin
    psel_nxt       = 1'b0;
    penable_nxt    = 1'b0;
    pwrite_nxt     = PWRITE;
    paddr_nxt      = PADDR;
    pwdata_nxt     = PWDATA;
    ack0_nxt       = 1'b0;
    ack1_nxt       = 1'b0;
    rv0_nxt        = 1'b0;
    rv1_nxt        = 1'b0;
    rdata0_nxt     = '0;
    rdata1_nxt     = '0;
    err0_nxt       = 1'b0;
    err1_nxt       = 1'b0;
    cnt_nxt        = cnt;
    last_grant_nxt = last_grant;
    case (state)
      IDLE: begin
        if (any_req_c) begin
          psel_nxt       = 1'b1;
          last_grant_nxt = gnt_c;
          if (gnt_c) begin
            pwrite_nxt = req1_write;
            paddr_nxt  = req1_addr;
            pwdata_nxt = req1_wdata;
            ack1_nxt   = 1'b1;
          end else begin
            pwrite_nxt = req0_write;
            paddr_nxt  = req0_addr;
            pwdata_nxt = req0_wdata;
            ack0_nxt   = 1'b1;
          end
        end
      end
      SETUP: begin
        psel_nxt    = 1'b1;
        penable_nxt = 1'b1;
        cnt_nxt     = '0;
      end
      ACCESS: begin
        if (done_c) begin
          // last_grant still names the client owning this transfer
          if (last_grant) begin
            rv1_nxt    = 1'b1;
            rdata1_nxt = rdata_c;
            err1_nxt   = err_c;
          end else begin
            rv0_nxt    = 1'b1;
            rdata0_nxt = rdata_c;
            err0_nxt   = err_c;
          end
        end else begin
          psel_nxt    = 1'b1;
          penable_nxt = 1'b1;
          cnt_nxt     = cnt + TWIDTH'(1);
        end
      end
      default: ;
    endcase
  end

  // Output and datapath registers
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      PSEL        <= 1'b0;
      PENABLE     <= 1'b0;
      PWRITE      <= 1'b0;
      PADDR       <= '0;
      PWDATA      <= '0;
      req0_ack    <= 1'b0;
      req1_ack    <= 1'b0;
      resp0_valid <= 1'b0;
      resp1_valid <= 1'b0;
      resp0_rdata <= '0;
      resp1_rdata <= '0;
      resp0_err   <= 1'b0;
      resp1_err   <= 1'b0;
      cnt         <= '0;
      last_grant  <= 1'b1;
    end else begin
      PSEL        <= psel_nxt;
      PENABLE     <= penable_nxt;
      PWRITE      <= pwrite_nxt;
      PADDR       <= paddr_nxt;
      PWDATA      <= pwdata_nxt;
      req0_ack    <= ack0_nxt;
      req1_ack    <= ack1_nxt;
      resp0_valid <= rv0_nxt;
      resp1_valid <= rv1_nxt;
      resp0_rdata <= rdata0_nxt;
      resp1_rdata <= rdata1_nxt;
      resp0_err   <= err0_nxt;
      resp1_err   <= err1_nxt;
      cnt         <= cnt_nxt;
      last_grant  <= last_grant_nxt;
    end
  end

endmodule

// File: tb/tb_apb_master_arb.sv
// Directed bench for apb_master_arb: read, write with wait states,
// round-robin order, slave error, timeout abort and mid-transfer reset.
module tb_apb_master_arb;

  localparam int unsigned AW = 4;
  localparam int unsigned DW = 8;

  logic          PCLK, PRESET;
  logic          req0_valid, req0_write, req0_ack, resp0_valid, resp0_err;
  logic [AW-1:0] req0_addr;
  logic [DW-1:0] req0_wdata, resp0_rdata;
  logic          req1_valid, req1_write, req1_ack, resp1_valid, resp1_err;
  logic [AW-1:0] req1_addr;
  logic [DW-1:0] req1_wdata, resp1_rdata;
  logic          PSEL, PENABLE, PWRITE, PREADY, PSLVERR;
  logic [AW-1:0] PADDR;
  logic [DW-1:0] PWDATA, PRDATA;

  int n_cmp = 0;
  int n_err = 0;

  apb_master_arb #(.AWIDTH(AW), .DWIDTH(DW), .TIMEOUT(15), .TWIDTH(4)) dut (
    .PCLK(PCLK), .PRESET(PRESET),
    .req0_valid(req0_valid), .req0_write(req0_write), .req0_addr(req0_addr),
    .req0_wdata(req0_wdata), .req0_ack(req0_ack), .resp0_valid(resp0_valid),
    .resp0_rdata(resp0_rdata), .resp0_err(resp0_err),
    .req1_valid(req1_valid), .req1_write(req1_write), .req1_addr(req1_addr),
    .req1_wdata(req1_wdata), .req1_ack(req1_ack), .resp1_valid(resp1_valid),
    .resp1_rdata(resp1_rdata), .resp1_err(resp1_err),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
    .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one cycle; drive and sample 1 time unit after the rising edge
  task automatic step();
    @(posedge PCLK);
    #1;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_psel"},    32'(PSEL), 0);
    check({tag, "_penable"}, 32'(PENABLE), 0);
    check({tag, "_pwrite"},  32'(PWRITE), 0);
    check({tag, "_paddr"},   32'(PADDR), 0);
    check({tag, "_pwdata"},  32'(PWDATA), 0);
    check({tag, "_acks"},    32'({req0_ack, req1_ack}), 0);
    check({tag, "_rvalid"},  32'({resp0_valid, resp1_valid}), 0);
    check({tag, "_rerr"},    32'({resp0_err, resp1_err}), 0);
    check({tag, "_rdata"},   32'({resp0_rdata, resp1_rdata}), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int gcnt;
    int pen;
    logic got;

    PRESET = 1'b1;
    req0_valid = 0; req0_write = 0; req0_addr = '0; req0_wdata = '0;
    req1_valid = 0; req1_write = 0; req1_addr = '0; req1_wdata = '0;
    PRDATA = '0; PREADY = 1'b1; PSLVERR = 1'b0;
    #2;
    check_idle_outputs("rst");
    step(); step();
    PRESET = 1'b0;
    step();

    // Read, zero wait states
    PRDATA = 8'hA5;
    req0_valid = 1; req0_write = 0; req0_addr = 4'd5;          // cycle 0
    step();                                                      // cycle 1
    check("rd_c1_psel", 32'(PSEL), 1);
    check("rd_c1_penable", 32'(PENABLE), 0);
    check("rd_c1_ack0", 32'(req0_ack), 1);
    check("rd_c1_paddr", 32'(PADDR), 5);
    check("rd_c1_pwrite", 32'(PWRITE), 0);
    req0_valid = 0;
    step();                                                      // cycle 2
    check("rd_c2_psel_en", 32'({PSEL, PENABLE}), 32'h3);
    check("rd_c2_ack0", 32'(req0_ack), 0);
    check("rd_c2_rv0", 32'(resp0_valid), 0);
    step();                                                      // cycle 3
    check("rd_c3_rv0", 32'(resp0_valid), 1);
    check("rd_c3_rdata", 32'(resp0_rdata), 32'hA5);
    check("rd_c3_err", 32'(resp0_err), 0);
    check("rd_c3_psel_en", 32'({PSEL, PENABLE}), 0);
    check("rd_c3_rv1", 32'(resp1_valid), 0);
    step();
    check("rd_c4_rv0", 32'(resp0_valid), 0);

    // Write with three wait states
    PREADY = 0; PRDATA = 8'hFF;
    req1_valid = 1; req1_write = 1; req1_addr = 4'd2; req1_wdata = 8'h3C;
    step();
    check("wr_c1_ack1", 32'(req1_ack), 1);
    check("wr_c1_pwrite", 32'(PWRITE), 1);
    req1_valid = 0;
    step();
    for (int i = 0; i < 3; i++) begin
      check($sformatf("wr_wait%0d_pen", i), 32'({PSEL, PENABLE}), 32'h3);
      check($sformatf("wr_wait%0d_pwdata", i), 32'(PWDATA), 32'h3C);
      check($sformatf("wr_wait%0d_rv1", i), 32'(resp1_valid), 0);
      step();
    end
    PREADY = 1;
    check("wr_ready_pwdata", 32'(PWDATA), 32'h3C);
    check("wr_ready_paddr", 32'(PADDR), 2);
    step();
    check("wr_rv1", 32'(resp1_valid), 1);
    check("wr_rdata", 32'(resp1_rdata), 0);
    check("wr_err", 32'(resp1_err), 0);
    check("wr_psel", 32'(PSEL), 0);
    step();
    check("wr_rv1_pulse", 32'(resp1_valid), 0);

    // Arbitration: both requesting continuously
    req0_valid = 1; req0_write = 0; req0_addr = 4'd1;
    req1_valid = 1; req1_write = 0; req1_addr = 4'd3;
    gcnt = 0;
    for (int c = 0; c < 40 && gcnt < 4; c++) begin
      step();
      if (req0_ack || req1_ack) begin
        check($sformatf("arb_excl%0d", gcnt), 32'({req0_ack, req1_ack}), (gcnt % 2) ? 32'h1 : 32'h2);
        check($sformatf("arb_paddr%0d", gcnt), 32'(PADDR), (gcnt % 2) ? 32'd3 : 32'd1);
        gcnt++;
        if (gcnt == 4) begin
          req0_valid = 0; req1_valid = 0;
        end
      end
    end
    check("arb_count", 32'(gcnt), 4);
    step(); step(); step();

    // Slave error on a read
    PRDATA = 8'h77; PSLVERR = 1;
    req0_valid = 1; req0_write = 0; req0_addr = 4'd9;
    step();
    check("err_ack0", 32'(req0_ack), 1);
    req0_valid = 0;
    step(); step();
    check("err_rv0", 32'(resp0_valid), 1);
    check("err_err", 32'(resp0_err), 1);
    check("err_rdata", 32'(resp0_rdata), 32'h77);
    PSLVERR = 0;
    step();

    // Timeout: slave never ready
    PREADY = 0; PSLVERR = 1; PRDATA = 8'h55;
    req1_valid = 1; req1_write = 0; req1_addr = 4'd4;
    step();
    check("to_ack1", 32'(req1_ack), 1);
    req1_valid = 0;
    pen = 0; got = 0;
    for (int c = 0; c < 40 && !got; c++) begin
      step();
      if (PENABLE) pen++;
      if (resp1_valid) begin
        got = 1;
        check("to_err", 32'(resp1_err), 1);
        check("to_rdata", 32'(resp1_rdata), 0);
        check("to_psel", 32'({PSEL, PENABLE}), 0);
      end
    end
    check("to_resp_seen", 32'(got), 1);
    check("to_access_cycles", 32'(pen), 15);
    PSLVERR = 0;
    step();

    // Reset during ACCESS; afterwards req0 wins the tie
    req0_valid = 1; req0_write = 1; req0_addr = 4'd6; req0_wdata = 8'h5A;
    step();
    check("rst_ack0", 32'(req0_ack), 1);
    req0_valid = 0;
    req1_valid = 1; req1_write = 0; req1_addr = 4'd7;
    step();
    check("rst_access", 32'({PSEL, PENABLE}), 32'h3);
    step();
    #3;
    PRESET = 1;
    #1;
    check_idle_outputs("rst_mid");
    req0_valid = 1;
    for (int c = 0; c < 2; c++) begin
      step();
      check($sformatf("rst_hold%0d_rv", c), 32'({resp0_valid, resp1_valid}), 0);
    end
    PRESET = 0;
    PREADY = 1;
    step();
    check("rst_after_acks", 32'({req0_ack, req1_ack}), 32'h2);
    check("rst_after_paddr", 32'(PADDR), 6);
    req0_valid = 0;
    step(); step();
    check("rst_after_rv0", 32'(resp0_valid), 1);
    step();
    check("rst_after_ack1", 32'(req1_ack), 1);
    req1_valid = 0;
    step(); step();
    check("rst_after_rv1", 32'(resp1_valid), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
